// File: rtl/it_seq_ctrl.sv
// -----------------------------------------------------------------------------
// it_seq_ctrl
//
// Sequencer for Thumb-2 IT blocks in the ARMv7-M core. Holds the live ITSTATE
// byte, loads it from a decoded IT instruction, advances it once per issued
// instruction and evaluates each instruction's condition against the APSR
// flags. Produces the execute/hint decision for pre-decode and exposes the
// ITSTATE byte for the EPSR IT field in the xPSR register block.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   inst_valid   an instruction (16- or 32-bit) issues this cycle
//   stall        issue held; ITSTATE frozen
//   it_load      issuing instruction is IT
//   it_field     {firstcond[3:0], mask[3:0]} from the IT instruction
//   flush        exception entry / branch out of block; clears ITSTATE
//   restore      exception return; ITSTATE <= restore_it
//   restore_it   stacked EPSR IT bits packed as ITSTATE[7:0]
//   apsr         {N,Z,C,V,Q}; Q is unused
//   itstate      current ITSTATE
//   in_it_blk    ITSTATE[3:0] != 0
//   cur_cond     condition of the current instruction (1110 outside a block)
//   cond_pass    current condition holds
//   hint_or_exc  execute the current instruction as a NOP
//   it_last      current instruction is the last of the block
//   it_remain    instructions left in the block, including the current one
//   it_err       one-cycle pulse after a rejected IT
// -----------------------------------------------------------------------------
module it_seq_ctrl #(
  parameter logic [7:0] RST_ITSTATE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_valid,
  input  logic       stall,
  input  logic       it_load,
  input  logic [7:0] it_field,
  input  logic       flush,
  input  logic       restore,
  input  logic [7:0] restore_it,
  input  logic [4:0] apsr,
  output logic [7:0] itstate,
  output logic       in_it_blk,
  output logic [3:0] cur_cond,
  output logic       cond_pass,
  output logic       hint_or_exc,
  output logic       it_last,
  output logic [2:0] it_remain,
  output logic       it_err
);

  // Base condition selected by cur_cond[3:1]; cur_cond[0] inverts the result
  // for every base except ALWAYS.
  typedef enum logic [2:0] {
    BASE_EQ  = 3'b000,  // Z
    BASE_CS  = 3'b001,  // C
    BASE_MI  = 3'b010,  // N
    BASE_VS  = 3'b011,  // V
    BASE_HI  = 3'b100,  // C & ~Z
    BASE_GE  = 3'b101,  // N == V
    BASE_GT  = 3'b110,  // (N == V) & ~Z
    BASE_AL  = 3'b111   // always
  } cond_base_e;

  logic [7:0] itstate_q, itstate_d;
  logic       it_err_q, it_err_d;

  logic       flag_n, flag_z, flag_c, flag_v;
  logic       issue;
  logic       it_illegal;
  logic       advance;
  logic       base_true;
  cond_base_e base_sel;

  assign flag_n = apsr[4];
  assign flag_z = apsr[3];
  assign flag_c = apsr[2];
  assign flag_v = apsr[1];

  // ---------------------------------------------------------------------------
  // Decoded view of the held ITSTATE
  // ---------------------------------------------------------------------------
  assign itstate   = itstate_q;
  assign in_it_blk = (itstate_q[3:0] != 4'b0000);
  assign it_last   = (itstate_q[3:0] == 4'b1000);
  assign cur_cond  = in_it_blk ? itstate_q[7:4] : 4'b1110;
  assign it_err    = it_err_q;

  // The lowest set bit of the mask marks the end of the block; its position
  // gives how many shifts remain before ITSTATE[3:0] empties.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    it_remain = 3'd0;
    if (itstate_q[0])      it_remain = 3'd4;
    else if (itstate_q[1]) it_remain = 3'd3;
    else if (itstate_q[2]) it_remain = 3'd2;
    else if (itstate_q[3]) it_remain = 3'd1;
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation against live flags. Outside a block cur_cond is
  // 1110 (AL), so cond_pass is 1 without a separate override.
  // ---------------------------------------------------------------------------
  assign base_sel = cond_base_e'(cur_cond[3:1]);

  always_comb begin
    base_true = 1'b1;
    unique case (base_sel)
      BASE_EQ: base_true = flag_z;
      BASE_CS: base_true = flag_c;
      BASE_MI: base_true = flag_n;
      BASE_VS: base_true = flag_v;
      BASE_HI: base_true = flag_c & ~flag_z;
      BASE_GE: base_true = (flag_n == flag_v);
      BASE_GT: base_true = (flag_n == flag_v) & ~flag_z;
      BASE_AL: base_true = 1'b1;
      default: base_true = 1'b1;
    endcase
  end

  assign cond_pass = (base_sel == BASE_AL) ? 1'b1 : (base_true ^ cur_cond[0]);

  // An IT instruction is never conditioned by the block it sits in; it either
  // loads a new block or is rejected.
  assign hint_or_exc = inst_valid & in_it_blk & ~cond_pass & ~it_load;

  // ---------------------------------------------------------------------------
  // Next-state selection
  // ---------------------------------------------------------------------------
  assign issue = inst_valid & ~stall;

  // Reject reserved/unpredictable encodings and any IT that is not the last
  // instruction of an enclosing block.
  assign it_illegal = (it_field[7:4] == 4'b1111) ||
                      ((it_field[7:4] == 4'b1110) && (it_field[3:0] != 4'b1000)) ||
                      (in_it_blk && !it_last);

  assign advance = issue & in_it_blk & ~it_load;

  always_comb begin
    itstate_d = itstate_q;
    it_err_d  = 1'b0;
    if (flush) begin
      itstate_d = 8'h00;
    end else if (restore) begin
      itstate_d = restore_it;
    end else if (issue && it_load) begin
      if (it_illegal) begin
        it_err_d = 1'b1;
      end else begin
        itstate_d = it_field;
      end
    end else if (advance) begin
      if (itstate_q[2:0] == 3'b000) begin
        itstate_d = 8'h00;
      end else begin
        // firstcond[3:1] stays; firstcond[0] is refilled from the mask so
        // each instruction picks up its own then/else polarity.
        itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      itstate_q <= RST_ITSTATE;
      it_err_q  <= 1'b0;
    end else begin
      itstate_q <= itstate_d;
      it_err_q  <= it_err_d;
    end
  end

endmodule

// File: tb/tb_it_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_it_seq_ctrl
//
// Scoreboard bench for it_seq_ctrl. Each stimulus step drives one cycle of
// inputs on the falling edge and pushes the outputs expected during that
// cycle; a monitor pops and compares shortly after the falling edge, well
// away from the rising edge that updates the DUT.
// -----------------------------------------------------------------------------
module tb_it_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       inst_valid;
  logic       stall;
  logic       it_load;
  logic [7:0] it_field;
  logic       flush;
  logic       restore;
  logic [7:0] restore_it;
  logic [4:0] apsr;
  logic [7:0] itstate;
  logic       in_it_blk;
  logic [3:0] cur_cond;
  logic       cond_pass;
  logic       hint_or_exc;
  logic       it_last;
  logic [2:0] it_remain;
  logic       it_err;

  typedef struct {
    logic [7:0] it;
    logic       pass;
    logic       hint;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  it_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .stall      (stall),
    .it_load    (it_load),
    .it_field   (it_field),
    .flush      (flush),
    .restore    (restore),
    .restore_it (restore_it),
    .apsr       (apsr),
    .itstate    (itstate),
    .in_it_blk  (in_it_blk),
    .cur_cond   (cur_cond),
    .cond_pass  (cond_pass),
    .hint_or_exc(hint_or_exc),
    .it_last    (it_last),
    .it_remain  (it_remain),
    .it_err     (it_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected remaining count: walk up from bit 0 to the first set mask bit.
  function automatic logic [2:0] remain_of(input logic [7:0] it);
    for (int i = 0; i < 4; i++) begin
      if (it[i]) return 3'(4 - i);
    end
    return 3'd0;
  endfunction

  // Monitor: compares each cycle's outputs against the popped expectation.
  initial begin
    exp_t e;
    logic blk;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        blk = (e.it[3:0] != 4'h0);
        check("itstate",     itstate,     e.it);
        check("in_it_blk",   8'(in_it_blk), 8'(blk));
        check("cur_cond",    8'(cur_cond),  blk ? 8'(e.it[7:4]) : 8'h0e);
        check("cond_pass",   8'(cond_pass), 8'(e.pass));
        check("hint_or_exc", 8'(hint_or_exc), 8'(e.hint));
        check("it_last",     8'(it_last),   8'(e.it[3:0] == 4'b1000));
        check("it_remain",   8'(it_remain), 8'(remain_of(e.it)));
        check("it_err",      8'(it_err),    8'(e.err));
      end
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic iv, input logic st, input logic ld,
                      input logic [7:0] fld, input logic fl, input logic rs,
                      input logic [7:0] rit, input logic r, input logic [4:0] ap,
                      input logic [7:0] e_it, input logic e_pass,
                      input logic e_hint, input logic e_err);
    exp_t e;
    @(negedge clk);
    inst_valid = iv;
    stall      = st;
    it_load    = ld;
    it_field   = fld;
    flush      = fl;
    restore    = rs;
    restore_it = rit;
    rst        = r;
    apsr       = ap;
    e.it   = e_it;
    e.pass = e_pass;
    e.hint = e_hint;
    e.err  = e_err;
    exp_q.push_back(e);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_Z    = 5'b01000;
  localparam logic [4:0] F_N    = 5'b10000;
  localparam logic [4:0] F_NV   = 5'b10010;

  initial begin
    rst = 1'b1; inst_valid = 1'b0; stall = 1'b0; it_load = 1'b0;
    it_field = 8'h00; flush = 1'b0; restore = 1'b0; restore_it = 8'h00;
    apsr = F_NONE;
    repeat (2) @(posedge clk);

    //   iv st ld fld    fl rs rit    rst apsr     it     pass hint err
    // Reset state
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // ITTE NE, apsr clear: NE, NE pass; EQ fails on the last instruction
    step(1, 0, 1, 8'h1A, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h1A, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h14, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h08, 0, 1, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // IT EQ held by stall for three cycles, then issues with Z=1
    step(1, 0, 1, 8'h08, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h08, 0, 1, 0);
    step(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h08, 0, 1, 0);
    step(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h08, 0, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_Z,    8'h08, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // ITT GE: first fails with N!=V, flag update V=1 makes the second pass
    step(1, 0, 1, 8'hA4, 0, 0, 8'h00, 0, F_N,    8'h00, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_N,    8'hA4, 0, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NV,   8'hA8, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // Reserved firstcond 1111: rejected, one-cycle error pulse
    step(1, 0, 1, 8'hF8, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 1);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // ITTTT EQ; nested IT at remain=3 is rejected; IT at the last slot loads
    step(1, 0, 1, 8'h01, 0, 0, 8'h00, 0, F_Z,    8'h00, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_Z,    8'h01, 1, 0, 0);
    step(1, 0, 1, 8'h1A, 0, 0, 8'h00, 0, F_Z,    8'h02, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_Z,    8'h02, 1, 0, 1);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h04, 0, 1, 0);
    step(1, 0, 1, 8'h1A, 0, 0, 8'h00, 0, F_NONE, 8'h08, 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h1A, 1, 0, 0);

    // Flush at remain=2, restore 8'h14 two cycles later
    step(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, F_NONE, 8'h14, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 1, 8'h14, 0, F_NONE, 8'h00, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h14, 1, 0, 0);

    // Flush together with an otherwise-rejected IT: flush wins, no error
    step(1, 0, 1, 8'hF8, 1, 0, 8'h00, 0, F_NONE, 8'h14, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // Reset mid-block with a simultaneous (illegal) IT
    step(1, 0, 1, 8'h1A, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h1A, 1, 0, 0);
    step(1, 0, 1, 8'hF8, 0, 0, 8'h00, 1, F_NONE, 8'h14, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);

    // Restore coinciding with an advance: restore wins
    step(1, 0, 1, 8'h1A, 0, 0, 8'h00, 0, F_NONE, 8'h00, 1, 0, 0);
    step(1, 0, 0, 8'h00, 0, 1, 8'h08, 0, F_NONE, 8'h1A, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_Z,    8'h08, 1, 0, 0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, F_Z,    8'h08, 1, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #5;
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
